// File: rtl/acq_frame_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acq_frame_ctrl_if : capture-FIFO / Ethernet-session frame handshake  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface acq_frame_ctrl_if;
  logic i_fifo_empty;
  logic i_sink_full;
  logic o_fifo_rd;
  logic o_frame_wr;
  logic o_frame_start;
  logic o_frame_done;
  logic o_frame_abort;

  modport master (
    input  i_fifo_empty, i_sink_full,
    output o_fifo_rd, o_frame_wr, o_frame_start, o_frame_done, o_frame_abort
  );

  modport slave (
    output i_fifo_empty, i_sink_full,
    input  o_fifo_rd, o_frame_wr, o_frame_start, o_frame_done, o_frame_abort
  );
endinterface
`default_nettype wire

// File: rtl/acq_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acq_frame_ctrl : trigger-driven frame scheduler, capture FIFO -> ETH |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module acq_frame_ctrl #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] TIMEOUT     = 16'd50000
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst_n,
  input  wire logic        i_run,
  input  wire logic        i_trig,
  input  wire logic [15:0] i_frame_size,
  acq_frame_ctrl_if.master bus,
  output logic [15:0]      o_frame_cnt,
  output logic [7:0]       o_drop_cnt,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    CLOSE  = 2'd2
  } state_t;

  localparam logic [15:0] c_wd_last = TIMEOUT - 16'd1;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise_q;
  logic [15:0]            size_q;
  logic [15:0]            byte_q;
  logic [15:0]            wd_q;
  logic [15:0]            frame_cnt_q;
  logic [7:0]             drop_q;
  logic                   start_q;
  logic                   done_q;
  logic                   abort_q;

  logic [15:0]            eff_size_w;
  logic [15:0]            byte_d;
  logic [7:0]             drop_d;
  logic                   rd_w;

  // Odd sizes round down to whole 16-bit FIFO words.
  assign eff_size_w = i_frame_size & 16'hFFFE;
  assign rd_w       = (state_q == STREAM) & ~bus.i_fifo_empty & ~bus.i_sink_full;
  assign byte_d     = byte_q + 16'd2;
  assign drop_d     = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;

  // Edge detect is registered so the FSM sees a clean one-cycle request.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_trig};
      hist_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      size_q      <= '0;
      byte_q      <= '0;
      wd_q        <= '0;
      frame_cnt_q <= '0;
      drop_q      <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      if (rise_q && state_q != IDLE) begin
        drop_q <= drop_d;
      end
      case (state_q)
        IDLE: begin
          if (rise_q && i_run && eff_size_w != 16'd0) begin
            state_q <= STREAM;
            size_q  <= eff_size_w;
            byte_q  <= '0;
            wd_q    <= '0;
            start_q <= 1'b1;
          end
        end
        STREAM: begin
          // Run drop wins; a read issued this cycle still went to the sink.
          if (!i_run) begin
            state_q <= IDLE;
            abort_q <= 1'b1;
          end else if (rd_w) begin
            byte_q <= byte_d;
            wd_q   <= '0;
            if (byte_d == size_q) begin
              state_q <= CLOSE;
              done_q  <= 1'b1;
            end
          end else if (wd_q == c_wd_last) begin
            state_q <= IDLE;
            abort_q <= 1'b1;
          end else begin
            wd_q <= wd_q + 16'd1;
          end
        end
        CLOSE: begin
          state_q     <= IDLE;
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_fifo_rd     = rd_w;
  assign bus.o_frame_wr    = (state_q == STREAM);
  assign bus.o_frame_start = start_q;
  assign bus.o_frame_done  = done_q;
  assign bus.o_frame_abort = abort_q;
  assign o_frame_cnt       = frame_cnt_q;
  assign o_drop_cnt        = drop_q;
  assign o_busy            = (state_q != IDLE);

endmodule
`default_nettype wire
